// File: rtl/tick_gen_pkg.sv
// Shared configuration for the tick_gen timebase: channel map, default rates
// and the accumulator word type used by tick_gen and tick_gen_chan.
package tick_gen_pkg;

    localparam int TICK_GEN_CHANNELS = 2;
    localparam int CH_RTC            = 0;
    localparam int CH_BAUD           = 1;

    localparam int SYS_CLK_FREQ      = 25000000;
    localparam int RTC_FREQ          = 32768;
    localparam int BAUDRATE          = 115200;

    localparam int TICK_ACC_W        = 32;
    typedef logic [TICK_ACC_W-1:0] acc_word_t;

    localparam acc_word_t INC_INIT_RTC  = acc_word_t'(RTC_FREQ);
    localparam acc_word_t INC_INIT_BAUD = acc_word_t'(BAUDRATE);

endpackage

// File: rtl/tick_gen_chan.sv
// One fractional tick channel: phase accumulator modulo CLK_FREQ, registered
// tick pulse and, when TICK_GEN_SQUARE_EN is defined, a square-wave output.
module tick_gen_chan
    import tick_gen_pkg::*;
#(
    parameter int               CLK_FREQ  = SYS_CLK_FREQ,
    parameter int               ACC_W     = TICK_ACC_W,
    parameter logic [ACC_W-1:0] INC_RESET = INC_INIT_RTC
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             wr_en,
    input  logic [ACC_W-1:0] wr_inc,
`ifdef TICK_GEN_SQUARE_EN
    output logic             sq,
`endif
    output logic             tick
);

    localparam logic [ACC_W-1:0] MODULUS = ACC_W'(CLK_FREQ);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic             tick_q, tick_d;
    logic [ACC_W:0]   sum_s;
    logic [ACC_W:0]   diff_s;
    logic [ACC_W-1:0] inc_clamped_s;
    logic             sq_q, sq_d;

    // Next-state: a write restarts the phase and wins over a same-cycle crossing
    always_comb begin
        sum_s  = {1'b0, acc_q} + {1'b0, inc_q};
        diff_s = sum_s - {1'b0, MODULUS};
        if (wr_inc > MODULUS) begin
            inc_clamped_s = MODULUS;
        end else begin
            inc_clamped_s = wr_inc;
        end
        acc_d  = acc_q;
        inc_d  = inc_q;
        tick_d = 1'b0;
        sq_d   = sq_q;
        if (wr_en) begin
            inc_d = inc_clamped_s;
            acc_d = {ACC_W{1'b0}};
            sq_d  = 1'b0;
        end else if (enable) begin
            if (sum_s >= {1'b0, MODULUS}) begin
                acc_d  = diff_s[ACC_W-1:0];
                tick_d = 1'b1;
                sq_d   = ~sq_q;
            end else begin
                acc_d  = sum_s[ACC_W-1:0];
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Channel state registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q  <= {ACC_W{1'b0}};
            inc_q  <= INC_RESET;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            inc_q  <= inc_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    assign tick = tick_q;
`ifdef TICK_GEN_SQUARE_EN
    assign sq   = sq_q;
`endif

endmodule

// File: rtl/tick_gen.sv
// Multi-channel fractional tick generator with run-time rate write port.
// Optional square-wave outputs are built when TICK_GEN_SQUARE_EN is defined.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int               CLK_FREQ = SYS_CLK_FREQ,
    parameter int               CHANNELS = TICK_GEN_CHANNELS,
    parameter int               ACC_W    = TICK_ACC_W,
    parameter logic [ACC_W-1:0] INC_INIT [CHANNELS] = '{INC_INIT_RTC, INC_INIT_BAUD}
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] enable,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [3:0]          wr_chan,
    input  logic [ACC_W-1:0]    wr_inc,
`ifdef TICK_GEN_SQUARE_EN
    output logic [CHANNELS-1:0] sq,
`endif
    output logic [CHANNELS-1:0] tick
);

    logic                wr_ready_q, wr_ready_d;
    logic                wr_fire_s;
    logic [CHANNELS-1:0] wr_en_s;

    // Write decode; addresses beyond the last channel match nothing and are dropped
    always_comb begin
        wr_ready_d = 1'b1;
        wr_fire_s  = wr_valid && wr_ready_q;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_en_s[i] = wr_fire_s && (wr_chan == 4'(i));
        end
    end

    // Ready register, low only while reset is held
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ready_q <= 1'b0;
        end else begin
            wr_ready_q <= wr_ready_d;
        end
    end

    assign wr_ready = wr_ready_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        tick_gen_chan #(
            .CLK_FREQ  (CLK_FREQ),
            .ACC_W     (ACC_W),
            .INC_RESET (INC_INIT[g])
        ) u_chan (
            .clock  (clock),
            .reset  (reset),
            .enable (enable[g]),
            .wr_en  (wr_en_s[g]),
            .wr_inc (wr_inc),
`ifdef TICK_GEN_SQUARE_EN
            .sq     (sq[g]),
`endif
            .tick   (tick[g])
        );
    end

endmodule

// File: tb/tb_tick_gen.sv
// Scoreboard bench for tick_gen (CLK_FREQ=10, INC_INIT={3,5}); the reference
// predicts ticks from floor(n*inc/CLK_FREQ) over enabled cycles since restart.
module tb_tick_gen;

    localparam int NCH = 2;
    localparam int F   = 10;
    localparam int AW  = 32;

    logic           clock = 1'b0;
    logic           reset;
    logic [NCH-1:0] enable;
    logic           wr_valid;
    logic           wr_ready;
    logic [3:0]     wr_chan;
    logic [AW-1:0]  wr_inc;
    logic [NCH-1:0] tick;
`ifdef TICK_GEN_SQUARE_EN
    logic [NCH-1:0] sq;
`endif

    always #5 clock = ~clock;

    tick_gen #(
        .CLK_FREQ (F),
        .CHANNELS (NCH),
        .ACC_W    (AW),
        .INC_INIT ('{32'd3, 32'd5})
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_chan  (wr_chan),
        .wr_inc   (wr_inc),
`ifdef TICK_GEN_SQUARE_EN
        .sq       (sq),
`endif
        .tick     (tick)
    );

    typedef struct packed {
        logic [NCH-1:0] tick;
        logic [NCH-1:0] sq;
        logic           rdy;
    } exp_t;

    exp_t           sb_q[$];
    longint         m_n   [NCH];
    longint         m_inc [NCH];
    longint         init_inc [NCH] = '{64'd3, 64'd5};
    logic [NCH-1:0] m_sq;
    logic           m_ready;
    int             checks   = 0;
    int             failures = 0;
    int             cyc      = 0;
    int             t0_log[$];
    int             t1_log[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Predict the effect of the coming edge, push it, then compare after the edge
    task automatic step();
        exp_t e;
        logic fire;
        fire   = wr_valid && m_ready;
        e.tick = '0;
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                m_n[c]   = 0;
                m_inc[c] = init_inc[c];
            end
            m_sq    = '0;
            m_ready = 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (fire && wr_chan == 4'(c)) begin
                    m_inc[c] = (longint'(wr_inc) > F) ? longint'(F) : longint'(wr_inc);
                    m_n[c]   = 0;
                    m_sq[c]  = 1'b0;
                end else if (enable[c]) begin
                    m_n[c]++;
                    if ((m_n[c] * m_inc[c]) / F != ((m_n[c] - 1) * m_inc[c]) / F) begin
                        e.tick[c] = 1'b1;
                        m_sq[c]   = ~m_sq[c];
                    end
                end
            end
            m_ready = 1'b1;
        end
        e.sq  = m_sq;
        e.rdy = m_ready;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        cyc++;
        e = sb_q.pop_front();
        check_eq("tick", tick, e.tick);
        check_eq("wr_ready", wr_ready, e.rdy);
`ifdef TICK_GEN_SQUARE_EN
        check_eq("sq", sq, e.sq);
`endif
        if (tick[0]) t0_log.push_back(cyc);
        if (tick[1]) t1_log.push_back(cyc);
    endtask

    task automatic check_schedule();
        int exp0 [6] = '{5, 8, 11, 15, 18, 21};
        int exp1 [3] = '{3, 5, 7};
        for (int i = 0; i < 6; i++) begin
            check_eq("sched_ch0", (t0_log.size() > i) ? t0_log[i] : -1, exp0[i]);
        end
        for (int i = 0; i < 3; i++) begin
            check_eq("sched_ch1", (t1_log.size() > i) ? t1_log[i] : -1, exp1[i]);
        end
    endtask

    task automatic write(input logic [3:0] ch, input logic [AW-1:0] inc);
        wr_valid = 1'b1;
        wr_chan  = ch;
        wr_inc   = inc;
        step();
        wr_valid = 1'b0;
    endtask

    initial begin
        int cnt;
        int guard;
        int first;
        reset    = 1'b1;
        enable   = '0;
        wr_valid = 1'b0;
        wr_chan  = 4'd0;
        wr_inc   = '0;
        m_ready  = 1'b0;
        m_sq     = '0;
        for (int c = 0; c < NCH; c++) begin
            m_n[c]   = 0;
            m_inc[c] = init_inc[c];
        end
        repeat (3) step();
        check_eq("reset_tick", tick, 0);
        check_eq("reset_ready", wr_ready, 0);

        // Free-running schedule from reset
        reset  = 1'b0;
        enable = 2'b11;
        cyc    = 1;
        t0_log.delete();
        t1_log.delete();
        repeat (22) step();
        check_schedule();

        // Write inc=CLK_FREQ while ch0 sits at acc=9: crossing suppressed
        guard = 0;
        while (((m_n[0] * m_inc[0]) % F) != 9 && guard < 20) begin
            step();
            guard++;
        end
        check_eq("acc9_reached", (m_n[0] * m_inc[0]) % F, 9);
        write(4'd0, 32'd10);
        check_eq("wr_suppress", tick[0], 0);
        cnt = 0;
        repeat (10) begin step(); cnt += int'(tick[0]); end
        check_eq("inc_full_count", cnt, 10);

        // Clamp above CLK_FREQ, then zero rate
        write(4'd0, 32'd25);
        cnt = 0;
        repeat (10) begin step(); cnt += int'(tick[0]); end
        check_eq("inc_clamp_count", cnt, 10);
        write(4'd0, 32'd0);
        cnt = 0;
        repeat (100) begin step(); cnt += int'(tick[0]); end
        check_eq("inc_zero_count", cnt, 0);

        // Pause ch0 for 7 cycles mid-period
        write(4'd0, 32'd3);
        repeat (12) step();
        enable[0] = 1'b0;
        cnt = 0;
        repeat (7) begin step(); cnt += int'(tick[0]); end
        check_eq("paused_count", cnt, 0);
        enable[0] = 1'b1;
        first = -1;
        for (int s = 1; s <= 6; s++) begin
            step();
            if (tick[0] && first < 0) first = s;
        end
        check_eq("resume_shift", first, 2);

        // Out-of-range channel write is accepted and ignored
        check_eq("ready_bad_chan", wr_ready, 1);
        write(4'd5, 32'd7);
        repeat (10) step();

        // One-cycle reset mid-run restarts the schedule
        reset = 1'b1;
        step();
        check_eq("mid_rst_tick", tick, 0);
        check_eq("mid_rst_ready", wr_ready, 0);
        reset = 1'b0;
        cyc   = 1;
        t0_log.delete();
        t1_log.delete();
        repeat (22) step();
        check_schedule();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
